// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and constants for the I/D cache memory arbiter
//
// Purpose: FSM state and grant encodings plus the physical line width,
//          shared by the arbiter, its bus interface and the testbench.
// Contents:
//   LINE_BITS    physical memory line width in bits
//   arb_state_t  IDLE / SERVE_I / SERVE_D
//   grant_t      GRANT_I / GRANT_D (identifies the requester served most recently)
package cache_arb_pkg;

  localparam int LINE_BITS = 256;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - bus bundle between the two caches, the arbiter and physical memory
//
// Purpose: groups the I-cache, D-cache and physical-memory signals.
// Modports:
//   slave   the arbiter's view: takes cache requests and memory responses,
//           drives cache responses and memory commands
//   master  the surrounding system's view (caches plus memory)
// Signals:
//   i_address/i_read -> i_rdata/i_resp                    I-cache fill port
//   d_address/d_read/d_write/d_wdata -> d_rdata/d_resp    D-cache port
//   pmem_address/pmem_read/pmem_write/pmem_wdata -> pmem_rdata/pmem_resp
interface cache_arbiter_if
  import cache_arb_pkg::*;
#(
  parameter int s_line = LINE_BITS
) ();

  logic [31:0]       i_address;
  logic              i_read;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;

  logic [31:0]       d_address;
  logic              d_read;
  logic              d_write;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;

  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata,
    input  pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata,
    output pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one physical memory port between I and D caches
//
// Purpose: samples requests in IDLE, latches the winner's aligned line address,
//          command and write data into registered pmem outputs, holds them until
//          pmem_resp, and returns the response to the winner only.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   asynchronous active-low reset
//   bus   cache_arbiter_if.slave (I-cache, D-cache and pmem signals)
// Parameters:
//   s_offset  line-offset bits forced to zero on pmem_address
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int s_offset = 5
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus
);

  localparam logic [31:0] OFFSET_MASK = ~((32'd1 << s_offset) - 32'd1);

  arb_state_t state;
  arb_state_t state_next;
  grant_t     last_grant;

  logic i_pending;
  logic d_pending;
  logic grant_i;
  logic grant_d;

  // Two-way round robin: on a tie the requester not served last wins.
  always_comb begin
    i_pending = bus.i_read;
    d_pending = bus.d_read | bus.d_write;
    grant_d   = (state == IDLE) && d_pending && (!i_pending || (last_grant == GRANT_I));
    grant_i   = (state == IDLE) && i_pending && !grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
        end else if (grant_i) begin
          state_next = SERVE_I;
        end
      end
      SERVE_I: if (bus.pmem_resp) state_next = IDLE;
      SERVE_D: if (bus.pmem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Responses are combinational so the winner sees its resp in the pmem_resp cycle.
  always_comb begin
    bus.i_resp  = 1'b0;
    bus.d_resp  = 1'b0;
    bus.i_rdata = '0;
    bus.d_rdata = '0;
    if (state == SERVE_I && bus.pmem_resp) begin
      bus.i_resp  = 1'b1;
      bus.i_rdata = bus.pmem_rdata;
    end
    if (state == SERVE_D && bus.pmem_resp) begin
      bus.d_resp  = 1'b1;
      bus.d_rdata = bus.pmem_rdata;
    end
  end

  // Registered pmem command. A D request with both read and write set is a
  // writeback, so pmem_read is only raised for a pure D fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pmem_address <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_wdata   <= '0;
      last_grant       <= GRANT_I;
    end else if (grant_d) begin
      bus.pmem_address <= bus.d_address & OFFSET_MASK;
      bus.pmem_read    <= ~bus.d_write;
      bus.pmem_write   <= bus.d_write;
      bus.pmem_wdata   <= bus.d_wdata;
      last_grant       <= GRANT_D;
    end else if (grant_i) begin
      bus.pmem_address <= bus.i_address & OFFSET_MASK;
      bus.pmem_read    <= 1'b1;
      bus.pmem_write   <= 1'b0;
      last_grant       <= GRANT_I;
    end else if (state != IDLE && bus.pmem_resp) begin
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_arbiter_if #(.s_line(LINE_BITS)) bus ();

  cache_arbiter #(.s_offset(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [255:0] PAT_AA = {32{8'hAA}};
  localparam logic [255:0] PAT_55 = {32{8'h55}};
  localparam logic [255:0] PAT_C3 = {32{8'hC3}};

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the pmem command after a request, checks it, answers after dly
  // cycles and checks the response routing, then drops the winner's request.
  task automatic serve(input string tag, input bit is_d, input bit exp_wr,
                       input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                       input int dly, input logic [255:0] rd);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.pmem_read || bus.pmem_write) && n < 8);
    chk({tag, "_lat"},  n, 1);
    chk({tag, "_addr"}, bus.pmem_address, exp_addr);
    chk({tag, "_rd"},   bus.pmem_read, !exp_wr);
    chk({tag, "_wr"},   bus.pmem_write, exp_wr);
    if (exp_wr) chk({tag, "_wdata"}, bus.pmem_wdata, exp_wdata);
    for (int i = 0; i < dly; i++) begin
      chk({tag, "_noresp"}, {bus.i_resp, bus.d_resp}, 2'b00);
      tick();
    end
    chk({tag, "_hold_addr"}, bus.pmem_address, exp_addr);
    chk({tag, "_hold_cmd"},  {bus.pmem_read, bus.pmem_write}, {!exp_wr, exp_wr});
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    #1;
    chk({tag, "_i_resp"},  bus.i_resp, !is_d);
    chk({tag, "_d_resp"},  bus.d_resp, is_d);
    chk({tag, "_i_rdata"}, bus.i_rdata, is_d ? 256'd0 : rd);
    chk({tag, "_d_rdata"}, bus.d_rdata, is_d ? rd : 256'd0);
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    if (is_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
    #1;
    chk({tag, "_cmd_clr"},  {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk({tag, "_resp_clr"}, {bus.i_resp, bus.d_resp}, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.i_address  = '0;
    bus.i_read     = 1'b0;
    bus.d_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_pmem_cmd",  {bus.pmem_read, bus.pmem_write}, 2'b00);
    chk("rst_pmem_addr", bus.pmem_address, 32'd0);
    chk("rst_pmem_wdat", bus.pmem_wdata, 256'd0);
    chk("rst_resp",      {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst_i_rdata",   bus.i_rdata, 256'd0);
    chk("rst_d_rdata",   bus.d_rdata, 256'd0);
    rst = 1'b1;
    tick();

    // I-cache fill, offset bits cleared, memory answers five cycles after request
    bus.i_address = 32'h0000_1234;
    bus.i_read    = 1'b1;
    serve("ifill", 1'b0, 1'b0, 32'h0000_1220, '0, 4, PAT_AA);
    tick();

    // D-cache writeback
    bus.d_address = 32'h8000_0040;
    bus.d_wdata   = PAT_55;
    bus.d_write   = 1'b1;
    serve("dwb", 1'b1, 1'b1, 32'h8000_0040, PAT_55, 3, '0);
    tick();

    // Simultaneous requests after reset: D first, then I, in every round
    do_reset();
    bus.i_address = 32'h0000_2000;
    bus.d_address = 32'h0000_3010;
    for (int r = 0; r < 4; r++) begin
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      serve($sformatf("rr%0d_d", r), 1'b1, 1'b0, 32'h0000_3000, '0, r, PAT_C3);
      serve($sformatf("rr%0d_i", r), 1'b0, 1'b0, 32'h0000_2000, '0, 1, PAT_AA);
      tick();
    end

    // Read and write together is a write only
    bus.d_address = 32'h0000_0044;
    bus.d_wdata   = PAT_C3;
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    serve("drw", 1'b1, 1'b1, 32'h0000_0040, PAT_C3, 2, '0);
    tick();

    // Asynchronous reset while serving I
    bus.i_address = 32'h0000_5000;
    bus.i_read    = 1'b1;
    tick();
    chk("arst_pre_rd", bus.pmem_read, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_rd",     bus.pmem_read, 1'b0);
    chk("arst_addr",   bus.pmem_address, 32'd0);
    chk("arst_i_resp", bus.i_resp, 1'b0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("arst_i_resp2", bus.i_resp, 1'b0);
    tick();
    bus.pmem_resp = 1'b0;
    rst = 1'b1;
    serve("arst_regrant", 1'b0, 1'b0, 32'h0000_5000, '0, 1, PAT_55);
    tick();

    // Stray pmem_resp in IDLE
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = PAT_AA;
    #1;
    chk("stray_resp",    {bus.i_resp, bus.d_resp}, 2'b00);
    chk("stray_i_rdata", bus.i_rdata, 256'd0);
    chk("stray_d_rdata", bus.d_rdata, 256'd0);
    tick();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    #1;
    chk("stray_cmd", {bus.pmem_read, bus.pmem_write}, 2'b00);
    bus.i_address = 32'h0000_6000;
    bus.i_read    = 1'b1;
    serve("stray_after", 1'b0, 1'b0, 32'h0000_6000, '0, 1, PAT_C3);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single 256-bit physical memory port between the instruction cache and the data cache. Sits between both cache instances (each with its own bus adapter) and physical memory. Latches the winning requester's line address, write data and command, drives one physical-memory transaction, and routes the response back to the winner only. Round-robin on contention, so neither cache can starve the other.

## Interface
- `s_line`, 256, line width in bits (matches the cache line and `pmem_rdata`/`pmem_wdata` width)
- `s_offset`, 5, line-offset bits; the low `s_offset` address bits are forced to 0 on `pmem_address`
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `i_address`  in  32  I-cache line address
- `i_read`  in  1  I-cache line fill request
- `i_rdata`  out  s_line  I-cache fill data
- `i_resp`  out  1  I-cache transaction complete
- `d_address`  in  32  D-cache line address
- `d_read`  in  1  D-cache line fill request
- `d_write`  in  1  D-cache writeback request
- `d_wdata`  in  s_line  D-cache writeback data
- `d_rdata`  out  s_line  D-cache fill data
- `d_resp`  out  1  D-cache transaction complete
- `pmem_address`  out  32  memory line address, registered
- `pmem_read`  out  1  memory read, registered
- `pmem_write`  out  1  memory write, registered
- `pmem_wdata`  out  s_line  memory write data, registered
- `pmem_rdata`  in  s_line  memory read data
- `pmem_resp`  in  1  memory transaction complete

## Operation
- Requester contract: a requester holds its command and operands stable from assertion until the cycle it sees its `resp`, then drops the command no later than the following cycle.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - `i_pending = i_read`; `d_pending = d_read | d_write`.
  - Only one pending: grant it.
  - Both pending: grant the requester not in `last_grant`.
  - On grant: latch address (offset bits zeroed), command and `d_wdata` into the pmem output registers; set `last_grant`; move to SERVE_x.
- SERVE_x:
  - Hold `pmem_*` constant.
  - On `pmem_resp`:
    - assert `x_resp` combinationally in the same cycle;
    - drive `x_rdata = pmem_rdata` in the same cycle;
    - clear `pmem_read`/`pmem_write` at the clock edge;
    - return to IDLE.
- `d_read` and `d_write` both high: treated as a write (writeback precedes fill). `pmem_read` stays 0.
- Non-granted requester: `resp` held 0; `rdata` driven 0.
- `pmem_resp` in IDLE: ignored, no `resp` to anyone.
- Requests changing while not granted: no effect. Arbitration samples only in IDLE.

## Timing
- Reset values:
  - state IDLE, `last_grant` = I, so D wins the first tie;
  - `pmem_read`, `pmem_write` = 0;
  - `pmem_address` = 0, `pmem_wdata` = 0;
  - `i_resp`, `d_resp` = 0, `i_rdata`, `d_rdata` = 0.
- Asynchronous reset mid-transaction: the transaction is abandoned, `pmem_*` deassert immediately, and no `resp` is issued.
- Latency:
  - request high in IDLE at cycle t → `pmem_read`/`pmem_write` high from cycle t+1;
  - `pmem_resp` at cycle k → `x_resp` at cycle k;
  - FSM is in IDLE at k+1, earliest next `pmem` command at k+2.
- Minimum arbitration overhead: one cycle per transaction. No back-to-back `pmem` commands.
- `pmem_read` and `pmem_write` are never high together.
- Exactly one `resp` pulse (one cycle) per granted transaction.

## Structure
- Package `cache_arb_pkg`:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D};
  - `grant_t` enum {GRANT_I, GRANT_D};
  - localparam `LINE_BITS` = 256.
- Single flat module; no sub-module. The two-way round-robin pick is a few lines of combinational logic.
- Integrates at the top level alongside two `cache` instances. Its pmem port replaces the direct cache-to-memory connection.

## Test plan
- Reset, then `i_read`, `i_address`=0x0000_1234, memory responds after 5 cycles with rdata=0xAA…AA → `pmem_address`=0x0000_1220 from t+1; `i_resp`=1 and `i_rdata`=0xAA…AA in the `pmem_resp` cycle; `d_resp` stays 0.
- `d_write` with `d_address`=0x8000_0040, `d_wdata`=0x55…55 → `pmem_write`=1, `pmem_wdata`=0x55…55 held until `pmem_resp`; then `d_resp` one-cycle pulse.
- `i_read` and `d_read` asserted in the same cycle right after reset:
  - D served first;
  - I granted with `pmem_read` high two cycles after `d_resp`;
  - then both re-requested → I already served last, so D wins again (alternation verified over 4 rounds).
- `d_read` and `d_write` both high → write only issued, `pmem_read` never 1.
- Assert `rst` low while SERVE_I with `pmem_read`=1 → `pmem_read` 0 before the next edge; no `i_resp`; after release, `i_read` still high is re-granted normally.
- Stray `pmem_resp` pulse in IDLE → no `resp` output, state stays IDLE.
